instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the single-issue RISC core. It holds the fetch program counter, issues one request at a time to instruction memory, and presents the returned instruction with its PC to the decode stage over a valid/ready handshake. Redirects from execute (branch/jump) override sequential PC+4 flow and squash any in-flight fetch.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock; the block uses this single clock
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
- imem_req  out  1  request strobe, one-cycle pulse
- imem_addr  out  ADDR_W  request address, valid when imem_req=1
- imem_rvalid  in  1  response valid, ≥1 cycle after imem_req
- imem_rdata  in  INSTR_W  response instruction
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_ready  in  1  decode accepts this cycle
- if_pc  out  ADDR_W  PC of if_instr
- if_instr  out  INSTR_W  fetched instruction

## Operation
- States: FETCH, WAIT, HOLD, DRAIN. Reset state FETCH, pc=RESET_PC.
- Reset values: imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0.
- FETCH: drive imem_req=1, imem_addr=pc for one cycle; -> WAIT.
- WAIT: on imem_rvalid latch if_instr=imem_rdata, if_pc=pc, if_valid=1; -> HOLD.
- HOLD: if_valid=1, outputs stable. On if_ready: if_valid=0, pc=pc+4; -> FETCH.
- Redirect (any state): pc=redirect_pc & ~3; if_valid cleared next cycle.
  - FETCH or HOLD -> FETCH. The request issued in the redirect cycle (FETCH) counts as outstanding -> DRAIN instead.
  - WAIT -> DRAIN (response still owed).
  - DRAIN: wait for imem_rvalid, discard data; -> FETCH. Further redirects in DRAIN only update pc.
- Redirect and if_ready same cycle: redirect wins; handshake void, pc takes redirect target, not pc+4. Decode flushes on the same redirect.
- redirect_valid while imem_rvalid in WAIT: response discarded, -> FETCH (nothing outstanding).
- imem_rvalid in FETCH/HOLD: protocol error, ignored.
- PC arithmetic modulo 2^ADDR_W; pc+4 from 2^ADDR_W-4 wraps to 0.
- Exactly one outstanding memory request at any time.

## Timing
- Request cycle N (imem_req=1); earliest rvalid N+1; if_valid rises N+2.
- Accept at cycle M (if_valid & if_ready) -> imem_req at M+1 with addr pc+4.
- Peak throughput with 1-cycle memory: one instruction per 3 cycles.
- Redirect at cycle R with no outstanding request: imem_req at R+1, addr=redirect_pc.
- rst_n assertion mid-operation: all outputs to reset values immediately (asynchronous); in-flight response after release is not expected (memory reset together).

## Structure
- Package fetch_pkg: state enum {FETCH, WAIT, HOLD, DRAIN}, constant PC_INC=4, RESET_PC default.
- Sub-module fetch_pc_reg: pc register with async reset to RESET_PC, load (redirect, masked), increment (accept), hold; priority load > increment.
- FSM and output register in instr_fetch top.

## Test plan
- Reset release, 1-cycle memory, if_ready=1: imem_addr 0x0,0x4,0x8 every 3 cycles; if_pc matches, if_instr equals returned data.
- if_ready=0 for 5 cycles in HOLD: if_valid, if_pc=0x4, if_instr stable; no imem_req issued.
- Memory latency 4 with redirect to 0x100 in WAIT: response discarded (no if_valid), next imem_addr=0x100 after rvalid.
- redirect_valid & if_ready same cycle in HOLD (pc=0x8, target 0x40): next imem_addr=0x40, never 0xC.
- redirect_pc=0x103: imem_addr=0x100; RESET_PC=32'hFFFF_FFFC accepted -> next imem_addr=0x0.
- rst_n low during WAIT: outputs zero asynchronously; after release first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states
//   PC_INC        : sequential PC step in bytes
//   RESET_PC_DFLT : default first fetch address after reset
package fetch_pkg;

  localparam int unsigned PC_INC        = 4;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request visible on the memory port (or about to be issued)
    WAIT  = 2'd1,  // request outstanding, response will be used
    HOLD  = 2'd2,  // instruction presented to decode
    DRAIN = 2'd3   // request outstanding, response will be discarded
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter register.
//   clk, rst_n : clock, async active-low reset (pc <- RESET_PC)
//   load_i     : take load_pc_i with bits [1:0] cleared (wins over inc_i)
//   load_pc_i  : load target
//   inc_i      : advance pc by PC_INC, wrapping modulo 2^ADDR_W
//   pc_o       : current pc
//   pc_next_c  : combinational value pc takes at the next edge
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_c
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next pc: load > increment > hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = {load_pc_i[ADDR_W-1:2], 2'b00};
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(PC_INC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_c = pc_d;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: one outstanding memory request at a time,
// fetched instruction handed to decode over valid/ready, redirects squash
// any in-flight fetch.
//   clk, rst_n                 : clock, async active-low reset
//   redirect_valid/redirect_pc : PC change from execute (bits [1:0] ignored)
//   imem_req/imem_addr         : one-cycle request strobe and address
//   imem_rvalid/imem_rdata     : memory response
//   if_valid/if_ready          : decode handshake
//   if_pc/if_instr             : instruction payload and its PC
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DFLT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  fetch_state_e       state_q,    state_d;
  logic               imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic               if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]  if_pc_q,    if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;

  logic [ADDR_W-1:0]  pc_cur;
  logic [ADDR_W-1:0]  pc_next_c;
  logic               pc_inc_c;
  logic               issue_c;

  // Accepted handshake advances pc; a same-cycle redirect voids it.
  assign pc_inc_c = (state_q == HOLD) && if_ready && !redirect_valid;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (redirect_valid),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc_c),
    .pc_o      (pc_cur),
    .pc_next_c (pc_next_c)
  );

  // Next state and registered outputs. The request register is loaded on the
  // edge that enters FETCH, so FETCH is the cycle in which imem_req is seen;
  // FETCH with imem_req_q low only occurs right after reset.
  always_comb begin
    state_d     = state_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    issue_c     = 1'b0;

    case (state_q)
      FETCH: begin
        if (imem_req_q) begin
          // A redirect in the request cycle leaves that request owed.
          state_d = redirect_valid ? DRAIN : WAIT;
        end else begin
          issue_c = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            issue_c = 1'b1;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_cur;
            if_instr_d = imem_rdata;
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect_valid || if_ready) begin
          if_valid_d = 1'b0;
          issue_c    = 1'b1;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          issue_c = 1'b1;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (redirect_valid) begin
      if_valid_d = 1'b0;
    end

    // New request uses the pc value after this edge (redirect target or pc+4).
    if (issue_c) begin
      state_d     = FETCH;
      imem_req_d  = 1'b1;
      imem_addr_d = pc_next_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// redirect/ready/latency traffic, all checked against a cycle-level model of
// the architectural pc, the single outstanding request and the decode slot.
module tb_instr_fetch;

  localparam int unsigned AW     = 32;
  localparam int unsigned IW     = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] pc_m, vpc_m, vinstr_m, o_addr, mem_addr, last_req_addr;
  bit          valid_m, req_due, outst, squash, first_edge, lat_rand;
  int          mem_cnt, lat, req_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pc_m = RST_PC; valid_m = 1'b0; req_due = 1'b0; outst = 1'b0; squash = 1'b0;
    first_edge = 1'b1; mem_cnt = 0; vpc_m = '0; vinstr_m = '0; o_addr = '0;
    mem_addr = '0; req_cnt = 0;
  endtask

  // One clock: check outputs (at negedge), drive inputs, advance the model
  // across the rising edge, return at the following negedge.
  task automatic cycle(input bit rdr, input logic [31:0] tgt, input bit rdy);
    logic        req_s;
    logic [31:0] addr_s;
    bit          rv, accept, disc;
    chk1("imem_req", imem_req, req_due);
    if (req_due) chk("imem_addr", imem_addr, pc_m);
    chk1("if_valid", if_valid, valid_m);
    if (valid_m) begin
      chk("if_pc", if_pc, vpc_m);
      chk("if_instr", if_instr, vinstr_m);
    end
    req_s  = imem_req;
    addr_s = imem_addr;
    rv     = (mem_cnt == 1);
    redirect_valid = rdr;
    redirect_pc    = tgt;
    if_ready       = rdy;
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(mem_addr) : $urandom;
    @(posedge clk);
    accept = valid_m && rdy && !rdr;
    if (mem_cnt > 0) mem_cnt--;
    if (req_s === 1'b1) begin
      chk1("single_outstanding", outst, 1'b0);
      outst = 1'b1; o_addr = addr_s; squash = rdr;
      last_req_addr = addr_s; req_cnt++;
      mem_addr = addr_s;
      mem_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat;
    end else if (outst && rdr) begin
      squash = 1'b1;
    end
    if (rdr || accept) valid_m = 1'b0;
    disc = 1'b0;
    if (rv) begin
      if (squash || rdr) begin
        disc = 1'b1;
      end else begin
        valid_m = 1'b1; vpc_m = o_addr; vinstr_m = mem_word(o_addr);
      end
      outst = 1'b0; squash = 1'b0;
    end
    req_due    = first_edge || accept || (!outst && (rdr || disc));
    pc_m       = rdr ? (tgt & ~32'h3) : (accept ? pc_m + 32'd4 : pc_m);
    first_edge = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (if_valid !== 1'b1 && n < 20) begin cycle(1'b0, '0, 1'b0); n++; end
    chk1("wait_valid_bound", n < 20, 1'b1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin cycle(1'b0, '0, 1'b0); n++; end
    chk1("wait_req_bound", n < 20, 1'b1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk1({tag, "_imem_req"}, imem_req, 1'b0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk1({tag, "_if_valid"}, if_valid, 1'b0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
  endtask

  initial begin
    lat = 1; lat_rand = 1'b0; last_req_addr = '0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // Sequential flow with 1-cycle memory, then 5-cycle stall on 0x4
    run(6, 1'b1);
    run(5, 1'b0);
    chk1("hold_valid", if_valid, 1'b1);
    chk("hold_pc", if_pc, 32'h4);
    chk("hold_req_count", 32'(req_cnt), 32'd2);

    // Accept 0x4, reach HOLD on 0x8, redirect and ready together
    cycle(1'b0, '0, 1'b1);
    wait_valid();
    chk("seq_pc_8", if_pc, 32'h8);
    cycle(1'b1, 32'h40, 1'b1);
    wait_req();
    chk("redir_ready_addr", imem_addr, 32'h40);

    // Latency 4, redirect to 0x100 while waiting
    lat = 4;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h100, 1'b0);
    wait_req();
    chk("drain_addr", imem_addr, 32'h100);

    // Unaligned redirect target
    lat = 1;
    cycle(1'b0, '0, 1'b0);
    wait_valid();
    chk("pc_100", if_pc, 32'h100);
    cycle(1'b1, 32'h103, 1'b0);
    wait_req();
    chk("masked_addr", imem_addr, 32'h100);

    // Asynchronous reset while waiting on a slow response
    lat = 4;
    cycle(1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_reset");
    redirect_valid = 1'b0; if_ready = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lat = 1;
    wait_req();
    chk("post_reset_addr", imem_addr, RST_PC);

    // PC wrap from the top of the address space
    cycle(1'b0, '0, 1'b0);
    wait_valid();
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_req();
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, '0, 1'b0);
    wait_valid();
    chk("top_pc", if_pc, 32'hFFFF_FFFC);
    cycle(1'b0, '0, 1'b1);
    wait_req();
    chk("wrap_addr", imem_addr, 32'h0);

    // Random traffic
    lat_rand = 1'b1;
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
